// File: rtl/avg_row_summarizer_if.sv
// Handshake bundle between the row-averaging stream, avg_row_summarizer and its consumer.
// Carries min_out only when ROW_MIN_EN is defined.
interface avg_row_summarizer_if #(
  parameter int COLS   = 8,
  parameter int ROWS   = 15,
  parameter int DATA_W = 8
);
  localparam int SUM_W = DATA_W + $clog2(COLS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum_out;
  logic [DATA_W-1:0] max_out;
  logic [RW-1:0]     row_idx;
  logic              frame_done;
  logic              overflow;
`ifdef ROW_MIN_EN
  logic [DATA_W-1:0] min_out;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, sum_out, max_out, row_idx, frame_done, overflow
`ifdef ROW_MIN_EN
    , output min_out
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, sum_out, max_out, row_idx, frame_done, overflow
`ifdef ROW_MIN_EN
    , input min_out
`endif
  );
endinterface

// File: rtl/avg_row_summarizer.sv
// Reduces each averaged row to {sum, max, row index} and buffers summaries in a FIFO.
// Optional row minimum is built when ROW_MIN_EN is defined.
module avg_row_summarizer #(
  parameter int COLS       = 8,
  parameter int ROWS       = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  avg_row_summarizer_if.slave bus
);
  localparam int SUM_W = DATA_W + $clog2(COLS);
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  function automatic logic [DATA_W-1:0] pix_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef ROW_MIN_EN
  function automatic logic [DATA_W-1:0] pix_min(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
`endif

  // Stage p0: column/row tracking and per-row accumulation
  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;
  logic [SUM_W-1:0]  sum_acc_p0;
  logic [DATA_W-1:0] max_acc_p0;
  logic [SUM_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] max_nxt;
  logic              first_pix;
  logic              push;
  logic              last_row;
`ifdef ROW_MIN_EN
  logic [DATA_W-1:0] min_acc_p0;
  logic [DATA_W-1:0] min_nxt;
`endif

  always_comb begin
    first_pix = (col_p0 == '0);
    sum_nxt   = first_pix ? SUM_W'(bus.in_data) : sum_acc_p0 + SUM_W'(bus.in_data);
    max_nxt   = first_pix ? bus.in_data : pix_max(max_acc_p0, bus.in_data);
`ifdef ROW_MIN_EN
    min_nxt   = first_pix ? bus.in_data : pix_min(min_acc_p0, bus.in_data);
`endif
    push      = bus.in_valid && (col_p0 == COL_LAST);
    last_row  = (row_p0 == ROW_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_p0     <= '0;
      row_p0     <= '0;
      sum_acc_p0 <= '0;
      max_acc_p0 <= '0;
`ifdef ROW_MIN_EN
      min_acc_p0 <= '0;
`endif
    end else if (bus.in_valid) begin
      sum_acc_p0 <= sum_nxt;
      max_acc_p0 <= max_nxt;
`ifdef ROW_MIN_EN
      min_acc_p0 <= min_nxt;
`endif
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= last_row ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // Stage p1: summary FIFO; a full FIFO still accepts a push when the head pops
  logic [SUM_W-1:0]  mem_sum [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_max [FIFO_DEPTH];
  logic [RW-1:0]     mem_row [FIFO_DEPTH];
  logic              mem_last[FIFO_DEPTH];
`ifdef ROW_MIN_EN
  logic [DATA_W-1:0] mem_min [FIFO_DEPTH];
`endif
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              overflow_q;
  logic              vld_p1;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              drop;

  always_comb begin
    vld_p1 = (cnt != '0);
    full   = (cnt == CNT_FULL);
    pop    = vld_p1 && bus.out_ready;
    wr_en  = push && (!full || pop);
    drop   = push && full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_sum[i]  <= '0;
        mem_max[i]  <= '0;
        mem_row[i]  <= '0;
        mem_last[i] <= 1'b0;
`ifdef ROW_MIN_EN
        mem_min[i]  <= '0;
`endif
      end
    end else begin
      if (wr_en) begin
        mem_sum[wr_ptr]  <= sum_nxt;
        mem_max[wr_ptr]  <= max_nxt;
        mem_row[wr_ptr]  <= row_p0;
        mem_last[wr_ptr] <= last_row;
`ifdef ROW_MIN_EN
        mem_min[wr_ptr]  <= min_nxt;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.sum_out    = mem_sum[rd_ptr];
  assign bus.max_out    = mem_max[rd_ptr];
  assign bus.row_idx    = mem_row[rd_ptr];
  assign bus.overflow   = overflow_q;
  // End of frame is signalled either by its summary leaving, or by it being lost
  assign bus.frame_done = (pop && mem_last[rd_ptr]) || (drop && last_row);
`ifdef ROW_MIN_EN
  assign bus.min_out    = mem_min[rd_ptr];
`endif
endmodule

// File: tb/tb_avg_row_summarizer.sv
// Directed bench for avg_row_summarizer: latency, full frame, saturation-free sums,
// overflow drop, simultaneous push/pop at full, and mid-row reset.
module tb_avg_row_summarizer;
  localparam int COLS       = 8;
  localparam int ROWS       = 15;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  avg_row_summarizer_if #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W)) bus ();

  avg_row_summarizer #(
    .COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  task automatic pix(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_row(input int base, input int inc);
    for (int c = 0; c < COLS; c++) pix(base + c * inc);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.sum_out), 0);
    chk("rst_max", 32'(bus.max_out), 0);
    chk("rst_row", 32'(bus.row_idx), 0);
    chk("rst_fdone", 32'(bus.frame_done), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    do_reset();

    // Single row of 0x10 with one-cycle latency
    for (int c = 0; c < COLS - 1; c++) pix(8'h10);
    chk("lat_not_yet", 32'(bus.out_valid), 0);
    pix(8'h10);
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("r10_sum", 32'(bus.sum_out), 32'h080);
    chk("r10_max", 32'(bus.max_out), 32'h10);
    chk("r10_row", 32'(bus.row_idx), 0);
    @(negedge clk);
    chk("r10_hold", 32'(bus.sum_out), 32'h080);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("r10_popped", 32'(bus.out_valid), 0);

    // Full frame, pixel = row*8+col, consumer always ready
    do_reset();
    bus.out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      send_row(r * 8, 1);
      chk($sformatf("frm_valid_r%0d", r), 32'(bus.out_valid), 1);
      chk($sformatf("frm_row_r%0d", r), 32'(bus.row_idx), 32'(r));
      chk($sformatf("frm_sum_r%0d", r), 32'(bus.sum_out), 32'(64 * r + 28));
      chk($sformatf("frm_max_r%0d", r), 32'(bus.max_out), 32'(r * 8 + 7));
      chk($sformatf("frm_fdone_r%0d", r), 32'(bus.frame_done), (r == ROWS - 1) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("frm_fdone_off_r%0d", r), 32'(bus.frame_done), 0);
    end
    send_row(0, 1);
    chk("frm_wrap_row", 32'(bus.row_idx), 0);
    chk("frm_wrap_sum", 32'(bus.sum_out), 28);

    // All 0xFF with idle gaps between pixels
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      repeat (c % 3) @(negedge clk);
      pix(8'hFF);
    end
    chk("ff_valid", 32'(bus.out_valid), 1);
    chk("ff_sum", 32'(bus.sum_out), 32'h7F8);
    chk("ff_max", 32'(bus.max_out), 32'hFF);

    // Overflow: five rows with consumer stalled, row 4 lost
    do_reset();
    for (int r = 0; r < 4; r++) send_row(r * 16, 1);
    chk("ovf_before", 32'(bus.overflow), 0);
    send_row(4 * 16, 1);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_fdone", 32'(bus.frame_done), 0);
    chk("ovf_head_row", 32'(bus.row_idx), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_drain_row%0d", k), 32'(bus.row_idx), 32'(k));
      chk($sformatf("ovf_drain_sum%0d", k), 32'(bus.sum_out), 32'(128 * k + 28));
      @(negedge clk);
    end
    chk("ovf_empty", 32'(bus.out_valid), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    bus.out_ready = 1'b0;

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int r = 0; r < 4; r++) send_row(r * 16, 1);
    for (int c = 0; c < COLS - 1; c++) pix(4 * 16 + c);
    bus.out_ready = 1'b1;
    pix(4 * 16 + COLS - 1);
    chk("pp_ovf", 32'(bus.overflow), 0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pp_row%0d", k), 32'(bus.row_idx), 32'(k));
      chk($sformatf("pp_sum%0d", k), 32'(bus.sum_out), 32'(128 * k + 28));
      @(negedge clk);
    end
    chk("pp_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Reset mid-row discards the partial row and the buffered summary
    do_reset();
    send_row(8'h20, 0);
    for (int c = 0; c < 3; c++) pix(8'h50);
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", 32'(bus.out_valid), 0);
    chk("mr_sum", 32'(bus.sum_out), 0);
    chk("mr_max", 32'(bus.max_out), 0);
    @(negedge clk);
    reset = 1'b0;
    send_row(2, 0);
    chk("mr_row", 32'(bus.row_idx), 0);
    chk("mr_sum2", 32'(bus.sum_out), 32'h010);
    chk("mr_max2", 32'(bus.max_out), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
